// File: rtl/am386_bus_ctrl_if.sv
// Am386SX local-bus bundle between the CPU pins, the bus-cycle sequencer and
// the single on-FPGA target port.
//   slave  : the sequencer (samples CPU cycle definition, drives READY#/target req)
//   master : the CPU/target side (drives ADS#, cycle definition, target ack)
interface am386_bus_ctrl_if;
    localparam int unsigned ADDR_W = 23;
    localparam int unsigned BCD_W  = 4;
    localparam int unsigned BE_W   = 2;
    localparam int unsigned TYPE_W = 3;

    // CPU side
    logic              ads_n;
    logic [BCD_W-1:0]  bcd;
    logic [BE_W-1:0]   be_n;
    logic [ADDR_W-1:0] addr;
    logic              ready_n;
    logic              na_n;
    // Target side
    logic              tgt_req;
    logic [TYPE_W-1:0] tgt_type;
    logic [ADDR_W-1:0] tgt_addr;
    logic [BE_W-1:0]   tgt_be_n;
    logic              tgt_lock;
    logic              tgt_ack;
    // Status
    logic              data_oe;
    logic              busy;
    logic              timeout_err;

    modport slave (
        input  ads_n, bcd, be_n, addr, tgt_ack,
        output ready_n, na_n, tgt_req, tgt_type, tgt_addr, tgt_be_n, tgt_lock,
               data_oe, busy, timeout_err
    );

    modport master (
        output ads_n, bcd, be_n, addr, tgt_ack,
        input  ready_n, na_n, tgt_req, tgt_type, tgt_addr, tgt_be_n, tgt_lock,
               data_oe, busy, timeout_err
    );
endinterface

// File: rtl/am386_bus_ctrl.sv
// Am386SX bus-cycle sequencer. Tracks the CLK2 phase, accepts ADS# at the end
// of T1, latches the cycle definition, hands forwarded cycles to the target
// over tgt_req/tgt_ack, inserts wait states and drives READY#. Halt/shutdown
// and undefined cycles complete internally. NA# is tied inactive.
// Ports:
//   clk   : CLK2 (one bus state = two clk)
//   reset : synchronous, active-high, shared with the CPU
//   bus   : am386_bus_ctrl_if.slave (CPU pins, target handshake, status)
// Parameters:
//   WAIT_MIN : extra T2 states beyond the one-wait-state minimum
//   TIMEOUT  : REQ bus states without ack before the watchdog fires
// Optional feature: define AM386_BUS_TIMEOUT_EN to enable the REQ watchdog;
// otherwise REQ waits indefinitely and timeout_err stays 0.
module am386_bus_ctrl #(
    parameter int unsigned WAIT_MIN = 0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            reset,
    am386_bus_ctrl_if.slave bus
);
    localparam int unsigned WC_W = $clog2(WAIT_MIN + 2);
    localparam int unsigned TO_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, REQ, RDY} state_t;

    state_t          state;
    logic            ph;
    logic [WC_W-1:0] wait_cnt;
    logic [TO_W-1:0] to_cnt;
    logic            ack_flag;
    logic            is_read;

    logic accept_c;
    logic internal_c;
    logic ack_now_c;
    logic wait_ok_c;
    logic to_fire_c;

    // Address pipelining is never offered.
    assign bus.na_n = 1'b1;

    // Per-edge decode of the sampled CPU/target inputs.
    always_comb begin
        accept_c   = 1'b0;
        internal_c = 1'b0;
        ack_now_c  = 1'b0;
        wait_ok_c  = 1'b0;
        to_fire_c  = 1'b0;
        // ADS# only counts at the end of T1, from IDLE or on the RDY exit edge.
        accept_c   = ph && !bus.ads_n && (state == IDLE || state == RDY);
        // D/C#=0 with W/R#=1 is halt/shutdown (101) or undefined (001).
        internal_c = (bus.bcd[1:0] == 2'b01);
        ack_now_c  = bus.tgt_ack && !ack_flag;
        wait_ok_c  = (wait_cnt >= WC_W'(WAIT_MIN));
`ifdef AM386_BUS_TIMEOUT_EN
        to_fire_c  = ph && !ack_flag && !bus.tgt_ack && (to_cnt == TO_W'(TIMEOUT - 1));
`else
        to_fire_c  = 1'b0;
`endif
    end

    // Phase tracking, cycle FSM and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ph              <= 1'b0;
            state           <= IDLE;
            wait_cnt        <= '0;
            to_cnt          <= '0;
            ack_flag        <= 1'b0;
            is_read         <= 1'b0;
            bus.ready_n     <= 1'b1;
            bus.tgt_req     <= 1'b0;
            bus.tgt_type    <= '0;
            bus.tgt_addr    <= '0;
            bus.tgt_be_n    <= '0;
            bus.tgt_lock    <= 1'b0;
            bus.data_oe     <= 1'b0;
            bus.busy        <= 1'b0;
            bus.timeout_err <= 1'b0;
        end else begin
            ph              <= ~ph;
            bus.timeout_err <= 1'b0;

            case (state)
                IDLE: ;
                REQ: begin
                    // First ack only; later acks in REQ are ignored.
                    if (ack_now_c) begin
                        ack_flag    <= 1'b1;
                        bus.tgt_req <= 1'b0;
                        bus.data_oe <= is_read;
                    end
                    if (ph) begin
                        if (wait_cnt != '1)
                            wait_cnt <= wait_cnt + WC_W'(1);
                        if (!ack_flag && to_cnt != '1)
                            to_cnt <= to_cnt + TO_W'(1);
                        if ((ack_flag || bus.tgt_ack) && wait_ok_c) begin
                            state       <= RDY;
                            bus.ready_n <= 1'b0;
                        end else if (to_fire_c) begin
                            // Watchdog: finish with the bus floating (reads FFFFh).
                            state           <= RDY;
                            bus.ready_n     <= 1'b0;
                            bus.tgt_req     <= 1'b0;
                            bus.timeout_err <= 1'b1;
                        end
                    end
                end
                RDY: begin
                    if (ph) begin
                        state       <= IDLE;
                        bus.ready_n <= 1'b1;
                        bus.data_oe <= 1'b0;
                        bus.busy    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // New cycle overrides the RDY exit when ADS# lands on the same edge.
            if (accept_c) begin
                state        <= REQ;
                bus.busy     <= 1'b1;
                bus.tgt_type <= bus.bcd[2:0];
                bus.tgt_addr <= bus.addr;
                bus.tgt_be_n <= bus.be_n;
                bus.tgt_lock <= ~bus.bcd[3];
                wait_cnt     <= '0;
                to_cnt       <= '0;
                ack_flag     <= internal_c;
                bus.tgt_req  <= ~internal_c;
                is_read      <= ~bus.bcd[0];
            end
        end
    end
endmodule
